// File: rtl/hbus_arb.sv
// Hart-to-memory arbiter: round-robin serialisation of line reads/writes onto one memory port,
// fill-data return, write-invalidate broadcast and a single AMO bus lock.
module hbus_arb #(
  parameter int N_HARTS = 2,
  parameter int LINE_W  = 512
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_HARTS*64-1:0]       h_addr,
  input  logic [N_HARTS-1:0]          h_rd,
  input  logic [N_HARTS-1:0]          h_wr,
  input  logic [N_HARTS*LINE_W-1:0]   h_data_out,
  output logic [LINE_W-1:0]           h_data_in,
  output logic [N_HARTS-1:0]          h_dv,
  output logic [63:0]                 h_inv_addr,
  output logic [N_HARTS-1:0]          h_inv,
  input  logic [N_HARTS-1:0]          h_amo_req,
  output logic [N_HARTS-1:0]          h_amo_ack,
  output logic [63:0]                 m_addr,
  output logic                        m_rd,
  output logic                        m_wr,
  output logic [LINE_W-1:0]           m_data_out,
  input  logic [LINE_W-1:0]           m_data_in,
  input  logic                        m_dv
);

  localparam int IW = (N_HARTS > 1) ? $clog2(N_HARTS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       gnt_q, gnt_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic                lock_q, lock_d;
  logic                wr_op_q, wr_op_d;
  logic                m_rd_q, m_rd_d;
  logic                m_wr_q, m_wr_d;
  logic [63:0]         m_addr_q, m_addr_d;
  logic [LINE_W-1:0]   m_data_out_q, m_data_out_d;
  logic [LINE_W-1:0]   h_data_in_q, h_data_in_d;
  logic [N_HARTS-1:0]  h_dv_q, h_dv_d;
  logic [N_HARTS-1:0]  h_inv_q, h_inv_d;
  logic [63:0]         h_inv_addr_q, h_inv_addr_d;

  logic [63:0]         addr_arr  [N_HARTS];
  logic [LINE_W-1:0]   wdata_arr [N_HARTS];
  logic [N_HARTS-1:0]  elig;
  logic                found_gnt, found_amo;
  logic [IW-1:0]       pick_gnt, pick_amo;

  function automatic logic [N_HARTS-1:0] onehot(input logic [IW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  generate
    for (genvar gi = 0; gi < N_HARTS; gi++) begin : g_slice
      assign addr_arr[gi]  = h_addr[gi*64 +: 64];
      assign wdata_arr[gi] = h_data_out[gi*LINE_W +: LINE_W];
    end
  endgenerate

  // Both searches start at rr_ptr and wrap, so the most recently served hart goes last.
  always_comb begin
    int idx;
    idx       = 0;
    elig      = h_rd | h_wr;
    if (lock_q) elig = elig & onehot(owner_q);
    found_gnt = 1'b0;
    pick_gnt  = '0;
    found_amo = 1'b0;
    pick_amo  = '0;
    for (int k = 0; k < N_HARTS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_HARTS) idx = idx - N_HARTS;
      if (!found_gnt && elig[idx]) begin
        found_gnt = 1'b1;
        pick_gnt  = IW'(idx);
      end
      if (!found_amo && h_amo_req[idx]) begin
        found_amo = 1'b1;
        pick_amo  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    lock_d       = lock_q;
    wr_op_d      = wr_op_q;
    m_rd_d       = m_rd_q;
    m_wr_d       = m_wr_q;
    m_addr_d     = m_addr_q;
    m_data_out_d = m_data_out_q;
    h_data_in_d  = h_data_in_q;
    h_inv_addr_d = h_inv_addr_q;
    h_dv_d       = '0;
    h_inv_d      = '0;

    case (state_q)
      IDLE: begin
        if (found_gnt) begin
          state_d      = BUSY;
          gnt_d        = pick_gnt;
          wr_op_d      = h_wr[pick_gnt];
          m_wr_d       = h_wr[pick_gnt];
          m_rd_d       = ~h_wr[pick_gnt];
          m_addr_d     = addr_arr[pick_gnt];
          m_data_out_d = wdata_arr[pick_gnt];
          rr_ptr_d     = (pick_gnt == IW'(N_HARTS - 1)) ? '0 : pick_gnt + IW'(1);
        end
      end
      BUSY: begin
        if (m_dv) begin
          state_d     = DONE;
          m_rd_d      = 1'b0;
          m_wr_d      = 1'b0;
          h_data_in_d = m_data_in;
          h_dv_d      = onehot(gnt_q);
          if (wr_op_q) begin
            h_inv_d      = ~onehot(gnt_q);
            h_inv_addr_d = m_addr_q;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // An in-flight transaction is unaffected by the owner dropping its lock request.
    if (lock_q) begin
      if (!h_amo_req[owner_q]) lock_d = 1'b0;
    end else if (state_q == IDLE && found_amo) begin
      lock_d  = 1'b1;
      owner_d = pick_amo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      owner_q      <= '0;
      lock_q       <= 1'b0;
      wr_op_q      <= 1'b0;
      m_rd_q       <= 1'b0;
      m_wr_q       <= 1'b0;
      m_addr_q     <= '0;
      m_data_out_q <= '0;
      h_data_in_q  <= '0;
      h_dv_q       <= '0;
      h_inv_q      <= '0;
      h_inv_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      lock_q       <= lock_d;
      wr_op_q      <= wr_op_d;
      m_rd_q       <= m_rd_d;
      m_wr_q       <= m_wr_d;
      m_addr_q     <= m_addr_d;
      m_data_out_q <= m_data_out_d;
      h_data_in_q  <= h_data_in_d;
      h_dv_q       <= h_dv_d;
      h_inv_q      <= h_inv_d;
      h_inv_addr_q <= h_inv_addr_d;
    end
  end

  assign h_data_in  = h_data_in_q;
  assign h_dv       = h_dv_q;
  assign h_inv      = h_inv_q;
  assign h_inv_addr = h_inv_addr_q;
  assign h_amo_ack  = lock_q ? onehot(owner_q) : '0;
  assign m_addr     = m_addr_q;
  assign m_rd       = m_rd_q;
  assign m_wr       = m_wr_q;
  assign m_data_out = m_data_out_q;

endmodule
